// File: rtl/upower_decode_queue.sv
// uPOWER fetch queue: DEPTH-entry FIFO feeding a registered field decoder with valid/ready output.
// The head word is classified into XO/X/D/B/I/DS; fields unused by the format read as zero.
module upower_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      fmt,
  output logic [5:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      bo,
  output logic [4:0]      bi,
  output logic [8:0]      xo9,
  output logic [9:0]      xo10,
  output logic            oe,
  output logic            rc,
  output logic            aa,
  output logic            lk,
  output logic [1:0]      xods,
  output logic [XLEN-1:0] si_ext,
  output logic [XLEN-1:0] bd_ext,
  output logic [XLEN-1:0] li_ext,
  output logic [XLEN-1:0] ds_ext,
  output logic [31:0]     raw
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    FMT_XO = 3'd0,
    FMT_X  = 3'd1,
    FMT_D  = 3'd2,
    FMT_B  = 3'd3,
    FMT_I  = 3'd4,
    FMT_DS = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [5:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      bo;
    logic [4:0]      bi;
    logic [8:0]      xo9;
    logic [9:0]      xo10;
    logic            oe;
    logic            rc;
    logic            aa;
    logic            lk;
    logic [1:0]      xods;
    logic [XLEN-1:0] si_ext;
    logic [XLEN-1:0] bd_ext;
    logic [XLEN-1:0] li_ext;
    logic [XLEN-1:0] ds_ext;
    logic [31:0]     raw;
  } dec_t;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  dec_t          r_out;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_load;
  logic [31:0]   w_head;
  logic [5:0]    w_op;
  dec_t          w_dec;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // in_ready depends only on occupancy and reset, never on out_ready
  assign in_ready = rst_n & ~w_full;
  assign w_push   = in_valid & in_ready;
  assign w_load   = ~w_empty & (~r_out_valid | out_ready);
  assign w_head   = r_mem[r_rptr];
  assign w_op     = w_head[31:26];

  always_comb begin
    w_dec        = '0;
    w_dec.opcode = w_op;
    w_dec.raw    = w_head;
    if (w_op == 6'd31 && (w_head[9:1] == 9'd266 || w_head[9:1] == 9'd40)) begin
      w_dec.fmt = FMT_XO;
      w_dec.rd  = w_head[25:21];
      w_dec.rs  = w_head[20:16];
      w_dec.rt  = w_head[15:11];
      w_dec.oe  = w_head[10];
      w_dec.xo9 = w_head[9:1];
      w_dec.rc  = w_head[0];
    end else if (w_op == 6'd31) begin
      w_dec.fmt  = FMT_X;
      w_dec.rd   = w_head[25:21];
      w_dec.rs   = w_head[20:16];
      w_dec.rt   = w_head[15:11];
      w_dec.xo10 = w_head[10:1];
      w_dec.rc   = w_head[0];
    end else if (w_op inside {6'd14, 6'd15, 6'd23, 6'd24, 6'd26, 6'd28, 6'd32,
                              6'd34, 6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44}) begin
      w_dec.fmt    = FMT_D;
      w_dec.rt     = w_head[25:21];
      w_dec.rd     = w_head[25:21];
      w_dec.rs     = w_head[20:16];
      w_dec.si_ext = {{(XLEN-16){w_head[15]}}, w_head[15:0]};
    end else if (w_op == 6'd19) begin
      w_dec.fmt    = FMT_B;
      w_dec.bo     = w_head[25:21];
      w_dec.bi     = w_head[20:16];
      w_dec.bd_ext = {{(XLEN-16){w_head[15]}}, w_head[15:2], 2'b00};
      w_dec.aa     = w_head[1];
      w_dec.lk     = w_head[0];
    end else if (w_op == 6'd18) begin
      w_dec.fmt    = FMT_I;
      w_dec.li_ext = {{(XLEN-26){w_head[25]}}, w_head[25:2], 2'b00};
      w_dec.aa     = w_head[1];
      w_dec.lk     = w_head[0];
    end else begin
      w_dec.fmt    = FMT_DS;
      w_dec.rd     = w_head[25:21];
      w_dec.rs     = w_head[20:16];
      w_dec.ds_ext = {{(XLEN-16){w_head[15]}}, w_head[15:2], 2'b00};
      w_dec.xods   = w_head[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_load) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_load) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign fmt       = r_out.fmt;
  assign opcode    = r_out.opcode;
  assign rd        = r_out.rd;
  assign rs        = r_out.rs;
  assign rt        = r_out.rt;
  assign bo        = r_out.bo;
  assign bi        = r_out.bi;
  assign xo9       = r_out.xo9;
  assign xo10      = r_out.xo10;
  assign oe        = r_out.oe;
  assign rc        = r_out.rc;
  assign aa        = r_out.aa;
  assign lk        = r_out.lk;
  assign xods      = r_out.xods;
  assign si_ext    = r_out.si_ext;
  assign bd_ext    = r_out.bd_ext;
  assign li_ext    = r_out.li_ext;
  assign ds_ext    = r_out.ds_ext;
  assign raw       = r_out.raw;

endmodule
